// File: rtl/serializer_tx_if.sv
// rtl/serializer_tx_if.sv - parallel word handshake into the serial transmitter
interface serializer_tx_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data_in;
  logic             data_valid_in;
  logic             data_ready_out;

  // Word producer: offers data_in/data_valid_in, sees data_ready_out
  modport master (
    output data_in,
    output data_valid_in,
    input  data_ready_out
  );

  // Transmitter side: takes the word when valid and ready meet at a clock edge
  modport slave (
    input  data_in,
    input  data_valid_in,
    output data_ready_out
  );
endinterface

// File: rtl/serializer_tx.sv
// rtl/serializer_tx.sv - parallel-to-serial transmitter with strobed bit output
module serializer_tx #(
  parameter int WIDTH       = 8,
  parameter int LEAD_CYCLES = 10,
  parameter int HIGH_CYCLES = 10,
  parameter int LOW_CYCLES  = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  serializer_tx_if.slave        data_if,
  input  logic                  rx_ready_in,
  output logic                  serial_out,
  output logic                  write_out,
  output logic                  busy_out,
  output logic [7:0]            words_sent_out
);

  // One shared cycle counter serves LEAD, BIT_HI and BIT_LO, so it is sized
  // for the largest of the three limits.
  localparam int MAX_LH  = (LEAD_CYCLES > HIGH_CYCLES) ? LEAD_CYCLES : HIGH_CYCLES;
  localparam int MAX_CYC = (MAX_LH > LOW_CYCLES) ? MAX_LH : LOW_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int BIT_W   = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'((LEAD_CYCLES > 0) ? LEAD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_RX = 3'd1;
  localparam logic [2:0] S_LEAD    = 3'd2;
  localparam logic [2:0] S_BIT_HI  = 3'd3;
  localparam logic [2:0] S_BIT_LO  = 3'd4;

  logic [2:0]       state;
  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_next;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             take_word;

  // The holding register is free whenever it is not carrying a queued word.
  assign data_if.data_ready_out = ~hold_valid;
  assign take_word              = data_if.data_valid_in & ~hold_valid;
  assign busy_out               = (state != S_IDLE);
  assign shift_next             = shift >> 1;

  // Holding register: captured on handshake, emptied when IDLE moves it into the shifter
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (take_word) begin
      hold_valid <= 1'b1;
      hold_data  <= data_if.data_in;
    end else if (state == S_IDLE && hold_valid) begin
      hold_valid <= 1'b0;
    end
  end

  // Word sequencer: wait for receiver, lead-in delay, then HIGH/LOW strobe per bit, LSB first
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      shift          <= '0;
      cnt            <= '0;
      bit_cnt        <= '0;
      serial_out     <= 1'b0;
      write_out      <= 1'b0;
      words_sent_out <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hold_valid) begin
            shift   <= hold_data;
            bit_cnt <= '0;
            cnt     <= '0;
            state   <= S_WAIT_RX;
          end
        end

        S_WAIT_RX: begin
          if (rx_ready_in) begin
            cnt <= '0;
            if (LEAD_CYCLES == 0) begin
              state      <= S_BIT_HI;
              write_out  <= 1'b1;
              serial_out <= shift[0];
            end else begin
              state <= S_LEAD;
            end
          end
        end

        S_LEAD: begin
          if (cnt == LEAD_LAST) begin
            cnt        <= '0;
            state      <= S_BIT_HI;
            write_out  <= 1'b1;
            serial_out <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BIT_HI: begin
          if (cnt == HIGH_LAST) begin
            cnt       <= '0;
            write_out <= 1'b0;
            state     <= S_BIT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BIT_LO: begin
          if (cnt == LOW_LAST) begin
            cnt   <= '0;
            shift <= shift_next;
            if (bit_cnt == BIT_LAST) begin
              // serial_out keeps the final bit while idle
              bit_cnt        <= '0;
              words_sent_out <= words_sent_out + 8'd1;
              state          <= S_IDLE;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              write_out  <= 1'b1;
              serial_out <= shift_next[0];
              state      <= S_BIT_HI;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          write_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_tx.sv
// tb/tb_serializer_tx.sv - directed bench for serializer_tx with a loopback receiver model
module tb_serializer_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_ready_in = 1'b0;
  logic       serial_out;
  logic       write_out;
  logic       busy_out;
  logic [7:0] words_sent_out;

  serializer_tx_if #(.WIDTH(8)) link ();

  serializer_tx #(
    .WIDTH      (8),
    .LEAD_CYCLES(10),
    .HIGH_CYCLES(10),
    .LOW_CYCLES (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .data_if       (link),
    .rx_ready_in   (rx_ready_in),
    .serial_out    (serial_out),
    .write_out     (write_out),
    .busy_out      (busy_out),
    .words_sent_out(words_sent_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Cycle stamp: value after the most recent rising edge
  always @(posedge clock) cyc <= cyc + 1;

  // Loopback receiver: samples serial_out at each write_out rise, LSB first
  int         rises[$];
  int         falls[$];
  logic [7:0] rx_words[$];
  logic       prev_w = 1'b0;
  int         nb = 0;
  logic [7:0] acc_w = 8'h00;

  always @(negedge clock) begin
    if (reset) begin
      nb     <= 0;
      prev_w <= 1'b0;
    end else begin
      prev_w <= write_out;
      if (write_out && !prev_w) begin
        rises.push_back(cyc);
        acc_w <= {serial_out, acc_w[7:1]};
        if (nb == 7) begin
          rx_words.push_back({serial_out, acc_w[7:1]});
          nb <= 0;
        end else begin
          nb <= nb + 1;
        end
      end
      if (!write_out && prev_w) falls.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] w, output int acc);
    acc = -1;
    link.data_in       = w;
    link.data_valid_in = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      if (link.data_ready_out) begin
        @(posedge clock);
        #1;
        acc = cyc;
        break;
      end
    end
    link.data_valid_in = 1'b0;
    if (acc < 0) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_words(input string tag, input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (words_sent_out == target[7:0]) break;
      tick(1);
    end
    check(tag, words_sent_out, target);
    @(negedge clock);
    #1;
  endtask

  int acc1, acc2, r0, f0, w0, c0;
  int n_before;

  initial begin
    link.data_in       = 8'h00;
    link.data_valid_in = 1'b0;

    // Reset state
    reset = 1'b1;
    tick(3);
    check("rst_serial", serial_out, 0);
    check("rst_write", write_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_words", words_sent_out, 0);
    check("rst_ready", link.data_ready_out, 1);
    reset = 1'b0;
    tick(2);

    // Single word 0x99: timing of first strobe, bit order, pulse shape
    rx_ready_in = 1'b1;
    r0 = rises.size();
    f0 = falls.size();
    w0 = rx_words.size();
    send(8'h99, acc1);
    check("t2_ready_held", link.data_ready_out, 0);
    wait_words("t2_words", 1, 400);
    check("t2_rise_count", rises.size() - r0, 8);
    check("t2_fall_count", falls.size() - f0, 8);
    if (rises.size() - r0 >= 8 && falls.size() - f0 >= 8) begin
      check("t2_first_rise", rises[r0] - acc1, 12);
      for (int i = 0; i < 8; i++) check($sformatf("t2_high_%0d", i), falls[f0+i] - rises[r0+i], 10);
      for (int i = 0; i < 7; i++) check($sformatf("t2_low_%0d", i), rises[r0+i+1] - falls[f0+i], 10);
    end
    if (rx_words.size() > w0) check("t2_word", rx_words[w0], 8'h99);
    else check("t2_word_missing", 32'd0, 32'd1);
    check("t2_busy_idle", busy_out, 0);
    check("t2_ready_idle", link.data_ready_out, 1);
    check("t2_serial_holds", serial_out, 1);

    // Queued second word while the first is shifting
    do_reset();
    rx_ready_in = 1'b1;
    w0 = rx_words.size();
    send(8'h99, acc1);
    send(8'hF0, acc2);
    check("t3_second_accept", acc2 - acc1, 2);
    tick(50);
    check("t3_ready_queued", link.data_ready_out, 0);
    check("t3_busy", busy_out, 1);
    wait_words("t3_words", 2, 800);
    check("t3_count", rx_words.size() - w0, 2);
    if (rx_words.size() - w0 >= 2) begin
      check("t3_word0", rx_words[w0], 8'h99);
      check("t3_word1", rx_words[w0+1], 8'hF0);
    end
    check("t3_ready_end", link.data_ready_out, 1);
    check("t3_serial_holds", serial_out, 1);

    // Receiver not ready: stall in WAIT_RX, then start, then ignore mid-word drop
    do_reset();
    rx_ready_in = 1'b0;
    r0 = rises.size();
    w0 = rx_words.size();
    send(8'h3C, acc1);
    tick(200);
    check("t4_no_strobe", rises.size() - r0, 0);
    check("t4_write_low", write_out, 0);
    check("t4_busy_wait", busy_out, 1);
    rx_ready_in = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 50; k++) begin
      if (rises.size() > r0) break;
      tick(1);
    end
    if (rises.size() > r0) check("t4_lead", rises[r0] - c0, 11);
    else check("t4_lead_timeout", 32'd0, 32'd1);
    tick(30);
    rx_ready_in = 1'b0;
    wait_words("t4_words", 1, 300);
    if (rx_words.size() > w0) check("t4_word", rx_words[w0], 8'h3C);
    else check("t4_word_missing", 32'd0, 32'd1);
    rx_ready_in = 1'b1;

    // Reset during bit 4 of 0xAA
    do_reset();
    rx_ready_in = 1'b1;
    r0 = rises.size();
    send(8'hAA, acc1);
    for (int k = 0; k < 300; k++) begin
      if (rises.size() >= r0 + 5) break;
      tick(1);
    end
    check("t5_reach_bit4", (rises.size() >= r0 + 5), 1);
    tick(3);
    reset = 1'b1;
    tick(1);
    check("t5_write", write_out, 0);
    check("t5_busy", busy_out, 0);
    check("t5_words", words_sent_out, 0);
    check("t5_ready", link.data_ready_out, 1);
    check("t5_serial", serial_out, 0);
    reset = 1'b0;
    n_before = rises.size();
    tick(40);
    check("t5_quiet", rises.size() - n_before, 0);
    check("t5_words_after", words_sent_out, 0);

    // Loopback into receiver queue model, then dequeue one word
    do_reset();
    rx_ready_in = 1'b1;
    w0 = rx_words.size();
    send(8'h99, acc1);
    send(8'hF0, acc2);
    wait_words("t6_words", 2, 800);
    check("t6_len2", rx_words.size() - w0, 2);
    if (rx_words.size() - w0 >= 2) begin
      check("t6_head0", rx_words[w0], 8'h99);
      w0 = w0 + 1;
      check("t6_len1", rx_words.size() - w0, 1);
      check("t6_head1", rx_words[w0], 8'hF0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
